// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep sequencer for an external counter with enable and synchronous load.
// Optional build macro COUNT_CHECK_EN adds a shadow count that aborts with err on divergence.
module updown_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [REPS_W-1:0] reps,
  input  logic [WIDTH-1:0]  count,
  output logic              cnt_en,
  output logic              cnt_up,
  output logic              cnt_load,
  output logic [WIDTH-1:0]  cnt_load_val,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [REPS_W-1:0] reps_done
);

  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  lo_q, hi_q;
  logic [REPS_W-1:0] reps_q;
  logic [REPS_W:0]   reps_inc;
  logic              err_nxt, accept, sweep_end, check_fail;

  assign reps_inc     = {1'b0, reps_done} + 1'b1;
  assign cnt_load_val = lo_q;

`ifdef COUNT_CHECK_EN
  // Shadow of the counter: follows every load/step we request.
  logic [WIDTH-1:0] exp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q <= '0;
    end else if (state == LOAD) begin
      exp_q <= lo_q;
    end else if (cnt_en) begin
      exp_q <= cnt_up ? exp_q + 1'b1 : exp_q - 1'b1;
    end
  end

  assign check_fail = ((state == UP) || (state == DOWN)) && (count != exp_q);
`else
  assign check_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    accept    = 1'b0;
    sweep_end = 1'b0;
    cnt_en    = 1'b0;
    cnt_up    = 1'b1;
    cnt_load  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if ((lo < hi) && (reps != '0)) begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        busy      = 1'b1;
        cnt_load  = 1'b1;
        state_nxt = abort ? IDLE : UP;
      end
      UP: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (check_fail) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (count == hi_q - 1'b1) begin
          state_nxt = DOWN;
        end
      end
      DOWN: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        cnt_up = 1'b0;
        if (abort) begin
          state_nxt = IDLE;
        end else if (check_fail) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (count == lo_q + 1'b1) begin
          // The counter lands on lo_q at this edge: one full sweep is complete.
          sweep_end = 1'b1;
          state_nxt = (reps_inc < {1'b0, reps_q}) ? UP : DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q      <= '0;
      hi_q      <= '0;
      reps_q    <= '0;
      reps_done <= '0;
      err       <= 1'b0;
    end else begin
      err <= err_nxt;
      if (accept) begin
        lo_q      <= lo;
        hi_q      <= hi;
        reps_q    <= reps;
        reps_done <= '0;
      end else if (sweep_end && (reps_done != '1)) begin
        reps_done <= reps_done + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: per-cycle expectations come from a transaction-level schedule
// built when a start is accepted, with a simple behavioural counter closing the loop.
module tb_updown_sweep_ctrl;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0] lo = '0, hi = '0, reps = '0;
  logic [3:0] count = 4'd0;
  logic       skip = 1'b0;
  logic       cnt_en, cnt_up, cnt_load, busy, done, err;
  logic [3:0] cnt_load_val, reps_done;

  updown_sweep_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .reps(reps), .count(count),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .busy(busy), .done(done),
    .err(err), .reps_done(reps_done)
  );

  always #5 clk = ~clk;

  // External counter; skip=1 makes it ignore one enabled step.
  always @(posedge clk) begin
    if (cnt_load)             count <= cnt_load_val;
    else if (cnt_en && !skip) count <= cnt_up ? count + 4'd1 : count - 4'd1;
  end

  typedef struct {
    logic busy, done, err, en, up, load;
    int   rd, cnt, lv;
  } exp_t;

  exp_t cur;
  exp_t sched[$];
  int   tests = 0, fails = 0;
  bit   model_on = 1'b0;
  int   busy_seen = 0, done_seen = 0, err_seen = 0, since = 0, done_at = -1;

  function automatic exp_t mk(logic b, logic d, logic e, logic en, logic up, logic ld,
                              int rd, int cnt, int lv);
    exp_t x;
    x.busy = b; x.done = d; x.err = e; x.en = en; x.up = up; x.load = ld;
    x.rd = rd; x.cnt = cnt; x.lv = lv;
    return x;
  endfunction

  task automatic check(string name, int act, int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Whole expected sequence for one accepted start: load, reps x (up phase, down phase), done.
  task automatic build(int l, int h, int r);
    sched.delete();
    sched.push_back(mk(1, 0, 0, 0, 1, 1, 0, -1, l));
    for (int k = 0; k < r; k++) begin
      for (int i = 0; i < h - l; i++) sched.push_back(mk(1, 0, 0, 1, 1, 0, k, l + i, -1));
      for (int i = 0; i < h - l; i++) sched.push_back(mk(1, 0, 0, 1, 0, 0, k, h - i, -1));
    end
    sched.push_back(mk(0, 1, 0, 0, 1, 0, r, l, -1));
  endtask

  task automatic step_model();
    if (cur.busy && abort) begin
      sched.delete();
      cur = mk(0, 0, 0, 0, 1, 0, cur.rd, -1, -1);
    end else if (sched.size() > 0) begin
      cur = sched.pop_front();
    end else if (!cur.busy && !cur.done && start && !abort) begin
      if ((lo < hi) && (reps != 0)) begin
        build(int'(lo), int'(hi), int'(reps));
        cur = sched.pop_front();
      end else begin
        cur = mk(0, 0, 1, 0, 1, 0, cur.rd, -1, -1);
      end
    end else begin
      cur = mk(0, 0, 0, 0, 1, 0, cur.rd, -1, -1);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (model_on) begin
      check("busy", busy, cur.busy);
      check("done", done, cur.done);
      check("err", err, cur.err);
      check("cnt_en", cnt_en, cur.en);
      check("cnt_up", cnt_up, cur.up);
      check("cnt_load", cnt_load, cur.load);
      check("reps_done", reps_done, cur.rd);
      if (cur.cnt >= 0) check("count", count, cur.cnt);
      if (cur.lv >= 0)  check("cnt_load_val", cnt_load_val, cur.lv);
    end
    busy_seen += busy;
    done_seen += done;
    err_seen  += err;
    if (done) done_at = since;
    since++;
    if (model_on) step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    busy_seen = 0; done_seen = 0; err_seen = 0; since = 0; done_at = -1;
  endtask

  task automatic run_seq(int l, int h, int r, int ncyc);
    lo = 4'(l); hi = 4'(h); reps = 4'(r);
    clear_stats();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (ncyc) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = mk(0, 0, 0, 0, 1, 0, 0, -1, -1);
    model_on = 1'b1;
    repeat (2) cycle();
    check("rst_busy", busy, 0);
    check("rst_cnt_up", cnt_up, 1);
    rst = 1'b1;
    cycle();

    // Basic sweep 2..5..2 once.
    run_seq(2, 5, 1, 12);
    check("seq1_busy_cycles", busy_seen, 7);
    check("seq1_done_cycle", done_at, 8);
    check("seq1_done_count", done_seen, 1);
    check("seq1_reps_done", reps_done, 1);
    check("seq1_final_count", count, 2);

    // Full range, three sweeps.
    run_seq(0, 15, 3, 100);
    check("seq2_busy_cycles", busy_seen, 91);
    check("seq2_done_count", done_seen, 1);
    check("seq2_reps_done", reps_done, 3);

    // Rejected starts.
    run_seq(7, 7, 1, 3);
    check("rej1_err", err_seen, 1);
    check("rej1_busy", busy_seen, 0);
    run_seq(3, 9, 0, 3);
    check("rej2_err", err_seen, 1);
    check("rej2_busy", busy_seen, 0);
    check("rej_reps_done_kept", reps_done, 3);

    // Abort in the 5th UP cycle with start held throughout.
    lo = 4'd1; hi = 4'd9; reps = 4'd2;
    clear_stats();
    start = 1'b1;
    cycle();
    repeat (5) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    start = 1'b0;
    #3;
    check("abort_cnt_en", cnt_en, 0);
    check("abort_busy", busy, 0);
    repeat (6) cycle();
    check("abort_no_done", done_seen, 0);
    check("abort_reps_done", reps_done, 0);
    check("abort_no_err", err_seen, 0);

    // Asynchronous reset mid-sweep.
    lo = 4'd0; hi = 4'd15; reps = 4'd3;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (10) cycle();
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cnt_en", cnt_en, 0);
    check("arst_cnt_load", cnt_load, 0);
    check("arst_cnt_up", cnt_up, 1);
    check("arst_load_val", cnt_load_val, 0);
    check("arst_reps_done", reps_done, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    sched.delete();
    cur = mk(0, 0, 0, 0, 1, 0, 0, -1, -1);
    cycle();
    rst = 1'b1;
    cycle();
    run_seq(4, 6, 2, 12);
    check("post_rst_busy_cycles", busy_seen, 9);
    check("post_rst_done", done_seen, 1);

    // Randomized traffic against the schedule model.
    repeat (3000) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 79) == 0);
      lo    = 4'($urandom_range(0, 15));
      hi    = 4'($urandom_range(0, 15));
      reps  = 4'($urandom_range(0, 3));
      cycle();
    end
    start = 1'b0;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    cycle();
    check("rand_idle_after_abort", busy, 0);

    // Counter misses one DOWN step.
    model_on = 1'b0;
    lo = 4'd2; hi = 4'd5; reps = 4'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    clear_stats();
    skip = 1'b1;
    cycle();
    skip = 1'b0;
    repeat (12) cycle();
`ifdef COUNT_CHECK_EN
    check("skip_err", err_seen, 1);
    check("skip_no_done", done_seen, 0);
    check("skip_reps_done", reps_done, 0);
`else
    check("skip_err", err_seen, 0);
    check("skip_done", done_seen, 1);
    check("skip_final_count", count, 2);
`endif
    check("skip_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
